// File: rtl/prbs_pkg.sv
// ---------------------------------------------------------------------------
// prbs_pkg -- shared constants for the PRBS generator.
//   MODE_FIBONACCI / MODE_GALOIS : encoding of the prbs_gen MODE parameter
//   N_MIN / N_MAX                : supported register lengths
//   tap_mask(n)                  : maximal-length XOR tap mask for length n,
//                                  bit (t-1) set for each 1-indexed tap t
// ---------------------------------------------------------------------------
package prbs_pkg;

   localparam int MODE_FIBONACCI = 0;
   localparam int MODE_GALOIS    = 1;

   localparam int N_MIN = 3;
   localparam int N_MAX = 16;

   function automatic logic [15:0] tap_mask(input int n);
      logic [15:0] mask;
      mask = 16'h0000;
      case (n)
         3:       mask = 16'h0006;  // 3,2
         4:       mask = 16'h000C;  // 4,3
         5:       mask = 16'h0014;  // 5,3
         6:       mask = 16'h0030;  // 6,5
         7:       mask = 16'h0060;  // 7,6
         8:       mask = 16'h00B8;  // 8,6,5,4
         9:       mask = 16'h0110;  // 9,5
         10:      mask = 16'h0240;  // 10,7
         11:      mask = 16'h0500;  // 11,9
         12:      mask = 16'h0829;  // 12,6,4,1
         13:      mask = 16'h100D;  // 13,4,3,1
         14:      mask = 16'h2015;  // 14,5,3,1
         15:      mask = 16'h6000;  // 15,14
         16:      mask = 16'hD008;  // 16,15,13,4
         default: mask = 16'h0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/prbs_next.sv
// ---------------------------------------------------------------------------
// prbs_next -- combinational LFSR next-state function.
//   Parameters: N (register length), MODE (MODE_FIBONACCI or MODE_GALOIS)
//   state : current LFSR state
//   next  : state after one shift
// Fibonacci shifts left and feeds the parity of the tap bits into bit 0;
// Galois shifts right and XORs the tap mask in when the outgoing bit is 1.
// ---------------------------------------------------------------------------
module prbs_next
   import prbs_pkg::*;
#(
   parameter int N    = 8,
   parameter int MODE = MODE_FIBONACCI
) (
   input  logic [N-1:0] state,
   output logic [N-1:0] next
);

   localparam logic [N-1:0] TAP_MASK = N'(tap_mask(N));

   generate
      if (MODE == MODE_GALOIS) begin : g_galois
         always_comb begin
            // NOTE: combinational blocks assign every output unconditionally
            // up front so no path can leave it unassigned and infer a latch.
            next = state >> 1;
            if (state[0]) begin
               next = next ^ TAP_MASK;
            end
         end
      end else begin : g_fibonacci
         always_comb begin
            next = {state[N-2:0], ^(state & TAP_MASK)};
         end
      end
   endgenerate

endmodule

// File: rtl/prbs_gen.sv
// ---------------------------------------------------------------------------
// prbs_gen -- maximal-length PRBS source with valid/ready output handshake.
//   Parameters: N (3..16, register length), MODE (0 Fibonacci, 1 Galois)
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset (state and seed back to 1)
//   seed_load  : load seed_in as new state and active seed (wins over a fire)
//   seed_in    : seed value; all-zero loads 1 and raises lockup
//   num_ready  : consumer accepts num this cycle
//   num_valid  : num is a valid sequence value (low in reset / load cycles)
//   num        : current LFSR state
//   wrap       : one-cycle pulse when the state has returned to the seed
//   lockup     : sticky, an all-zero state was seen and repaired
// ---------------------------------------------------------------------------
module prbs_gen
   import prbs_pkg::*;
#(
   parameter int N    = 8,
   parameter int MODE = MODE_FIBONACCI
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         seed_load,
   input  logic [N-1:0] seed_in,
   input  logic         num_ready,
   output logic         num_valid,
   output logic [N-1:0] num,
   output logic         wrap,
   output logic         lockup
);

   generate
      if (N < N_MIN || N > N_MAX) begin : g_bad_n
         $error("prbs_gen: N must be in 3..16");
      end
      if (MODE != MODE_FIBONACCI && MODE != MODE_GALOIS) begin : g_bad_mode
         $error("prbs_gen: MODE must be 0 or 1");
      end
   endgenerate

   localparam logic [N-1:0] ONE = N'(1);

   logic [N-1:0] state;
   logic [N-1:0] seed;
   logic [N-1:0] next;
   logic         fire;

   prbs_next #(
      .N    (N),
      .MODE (MODE)
   ) u_next (
      .state (state),
      .next  (next)
   );

   // Valid is withheld only while reset or a reload is in progress, so the
   // first value after either is presented in the very next cycle.
   always_comb begin
      num_valid = !rst && !seed_load;
      fire      = num_valid && num_ready;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      if (rst) begin
         state  <= ONE;
         seed   <= ONE;
         wrap   <= 1'b0;
         lockup <= 1'b0;
      end else if (seed_load) begin
         // An all-zero seed would freeze the LFSR; substitute 1 and flag it.
         if (seed_in == '0) begin
            state  <= ONE;
            seed   <= ONE;
            lockup <= 1'b1;
         end else begin
            state <= seed_in;
            seed  <= seed_in;
         end
         wrap <= 1'b0;
      end else if (state == '0) begin
         // Defensive repair of a corrupted state; this cycle is not a fire.
         state  <= ONE;
         lockup <= 1'b1;
         wrap   <= 1'b0;
      end else if (fire) begin
         state <= next;
         wrap  <= (next == seed);
      end else begin
         wrap <= 1'b0;
      end
   end

   assign num = state;

endmodule

// File: tb/tb_prbs_gen.sv
// ---------------------------------------------------------------------------
// tb_prbs_gen -- self-checking bench for prbs_gen.
// Six instances (N = 4, 8, 16 in both modes) share clk/rst/seed_load/
// num_ready and a 16-bit seed truncated to each width. A reference model
// built from the tap lists and the handshake rules predicts every output
// every cycle; directed steps add literal sequence, load, reset and
// full-period distinct-value checks.
// ---------------------------------------------------------------------------
module tb_prbs_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        seed_load;
   logic        num_ready;
   logic [15:0] seed_in;

   always #5 clk = ~clk;

   logic [3:0]  n_4f, n_4g;
   logic [7:0]  n_8f, n_8g;
   logic [15:0] n_16f, n_16g;
   logic        v_4f, v_4g, v_8f, v_8g, v_16f, v_16g;
   logic        w_4f, w_4g, w_8f, w_8g, w_16f, w_16g;
   logic        l_4f, l_4g, l_8f, l_8g, l_16f, l_16g;

   prbs_gen #(.N(4), .MODE(0)) u_4f (.clk(clk), .rst(rst), .seed_load(seed_load),
      .seed_in(seed_in[3:0]), .num_ready(num_ready), .num_valid(v_4f), .num(n_4f),
      .wrap(w_4f), .lockup(l_4f));
   prbs_gen #(.N(4), .MODE(1)) u_4g (.clk(clk), .rst(rst), .seed_load(seed_load),
      .seed_in(seed_in[3:0]), .num_ready(num_ready), .num_valid(v_4g), .num(n_4g),
      .wrap(w_4g), .lockup(l_4g));
   prbs_gen #(.N(8), .MODE(0)) u_8f (.clk(clk), .rst(rst), .seed_load(seed_load),
      .seed_in(seed_in[7:0]), .num_ready(num_ready), .num_valid(v_8f), .num(n_8f),
      .wrap(w_8f), .lockup(l_8f));
   prbs_gen #(.N(8), .MODE(1)) u_8g (.clk(clk), .rst(rst), .seed_load(seed_load),
      .seed_in(seed_in[7:0]), .num_ready(num_ready), .num_valid(v_8g), .num(n_8g),
      .wrap(w_8g), .lockup(l_8g));
   prbs_gen #(.N(16), .MODE(0)) u_16f (.clk(clk), .rst(rst), .seed_load(seed_load),
      .seed_in(seed_in), .num_ready(num_ready), .num_valid(v_16f), .num(n_16f),
      .wrap(w_16f), .lockup(l_16f));
   prbs_gen #(.N(16), .MODE(1)) u_16g (.clk(clk), .rst(rst), .seed_load(seed_load),
      .seed_in(seed_in), .num_ready(num_ready), .num_valid(v_16g), .num(n_16g),
      .wrap(w_16g), .lockup(l_16g));

   logic [15:0] o_num  [6];
   logic        o_val  [6];
   logic        o_wrap [6];
   logic        o_lock [6];

   assign o_num[0] = 16'(n_4f);  assign o_val[0] = v_4f;  assign o_wrap[0] = w_4f;  assign o_lock[0] = l_4f;
   assign o_num[1] = 16'(n_4g);  assign o_val[1] = v_4g;  assign o_wrap[1] = w_4g;  assign o_lock[1] = l_4g;
   assign o_num[2] = 16'(n_8f);  assign o_val[2] = v_8f;  assign o_wrap[2] = w_8f;  assign o_lock[2] = l_8f;
   assign o_num[3] = 16'(n_8g);  assign o_val[3] = v_8g;  assign o_wrap[3] = w_8g;  assign o_lock[3] = l_8g;
   assign o_num[4] = n_16f;      assign o_val[4] = v_16f; assign o_wrap[4] = w_16f; assign o_lock[4] = l_16f;
   assign o_num[5] = n_16g;      assign o_val[5] = v_16g; assign o_wrap[5] = w_16g; assign o_lock[5] = l_16g;

   int checks = 0;
   int errors = 0;

   // Reference model state, one entry per instance.
   int unsigned m_state [6];
   int unsigned m_seed  [6];
   bit          m_wrap  [6];
   bit          m_lock  [6];
   int unsigned fires_since [6];
   int unsigned wraps_seen  [6];
   int unsigned collected   [6];
   int unsigned distinct    [6];
   int unsigned zeros       [6];
   bit          seen [6][65536];
   bit          chk_en     = 1'b0;
   bit          collect_en = 1'b0;

   function automatic int n_of(input int i);
      return (i < 2) ? 4 : ((i < 4) ? 8 : 16);
   endfunction

   function automatic int unsigned period_of(input int i);
      return (32'd1 << n_of(i)) - 32'd1;
   endfunction

   // Next value from the tap list: Fibonacci shifts left with the tap
   // parity entering at the bottom, Galois shifts right and folds the taps
   // in when a 1 falls out.
   function automatic int unsigned ref_next(input int n, input int mode, input int unsigned s);
      int          taps[$];
      int unsigned mask;
      int unsigned r;
      int unsigned fb;
      mask = (32'd1 << n) - 32'd1;
      case (n)
         4:       taps = '{4, 3};
         8:       taps = '{8, 6, 5, 4};
         16:      taps = '{16, 15, 13, 4};
         default: taps = '{};
      endcase
      if (mode == 0) begin
         fb = 0;
         foreach (taps[k]) fb = fb ^ ((s >> (taps[k] - 1)) & 32'd1);
         r = ((s << 1) | fb) & mask;
      end else begin
         r = s >> 1;
         if ((s & 32'd1) != 0) begin
            foreach (taps[k]) r = r ^ (32'd1 << (taps[k] - 1));
         end
      end
      return r;
   endfunction

   task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
      end
   endtask

   // One clock: compare at the falling edge, advance the model, then let
   // the rising edge happen and return 1 time unit after it.
   task automatic cycle();
      int unsigned ns [6];
      int unsigned nsd [6];
      bit          nw [6];
      bit          nl [6];
      bit          exp_valid;
      bit          fire;
      int unsigned v;
      @(negedge clk);
      exp_valid = !rst && !seed_load;
      fire      = exp_valid && num_ready;
      for (int i = 0; i < 6; i++) begin
         if (chk_en) begin
            chk("num", i, 32'(o_num[i]), m_state[i]);
            chk("num_valid", i, 32'(o_val[i]), 32'(exp_valid));
            chk("wrap", i, 32'(o_wrap[i]), 32'(m_wrap[i]));
            chk("lockup", i, 32'(o_lock[i]), 32'(m_lock[i]));
            if (o_wrap[i] === 1'b1) begin
               chk("wrap_spacing", i, fires_since[i], period_of(i));
               fires_since[i] = 0;
               wraps_seen[i]++;
            end
         end
         if (collect_en && collected[i] < period_of(i)) begin
            if (!seen[i][o_num[i]]) distinct[i]++;
            seen[i][o_num[i]] = 1'b1;
            if (o_num[i] == 16'd0) zeros[i]++;
            collected[i]++;
         end
         ns[i]  = m_state[i];
         nsd[i] = m_seed[i];
         nl[i]  = m_lock[i];
         nw[i]  = 1'b0;
         if (rst) begin
            ns[i] = 1; nsd[i] = 1; nl[i] = 1'b0;
         end else if (seed_load) begin
            v = 32'(seed_in) & ((32'd1 << n_of(i)) - 32'd1);
            if (v == 0) begin
               v = 1; nl[i] = 1'b1;
            end
            ns[i] = v; nsd[i] = v;
         end else if (fire) begin
            ns[i] = ref_next(n_of(i), i % 2, m_state[i]);
            nw[i] = (ns[i] == m_seed[i]);
         end
         if (rst || seed_load) fires_since[i] = 0;
         else if (fire) fires_since[i]++;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) begin
         m_state[i] = ns[i];
         m_seed[i]  = nsd[i];
         m_wrap[i]  = nw[i];
         m_lock[i]  = nl[i];
      end
   endtask

   logic [3:0] fib_ref [16];
   logic [3:0] gal_ref [6];
   int         wrap_at;

   initial begin
      fib_ref = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10,
                  4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8, 4'd1};
      gal_ref = '{4'd1, 4'd12, 4'd6, 4'd3, 4'd13, 4'd10};
      for (int i = 0; i < 6; i++) begin
         fires_since[i] = 0; wraps_seen[i] = 0; collected[i] = 0;
         distinct[i] = 0; zeros[i] = 0;
      end

      // Reset with a competing seed_load; reset must win.
      rst = 1'b1; seed_load = 1'b1; seed_in = 16'h00A5; num_ready = 1'b1;
      cycle();
      chk_en = 1'b1;
      cycle();

      // Continuous fires from reset: literal N=4 sequences and wrap timing.
      rst = 1'b0; seed_load = 1'b0;
      for (int k = 0; k < 16; k++) begin
         chk("fib4_seq", k, 32'(o_num[0]), 32'(fib_ref[k]));
         if (k < 6) chk("gal4_seq", k, 32'(o_num[1]), 32'(gal_ref[k]));
         if (k == 14) chk("fib4_wrap_early", k, 32'(o_wrap[0]), 32'd0);
         if (k == 15) chk("fib4_wrap", k, 32'(o_wrap[0]), 32'd1);
         cycle();
      end

      // Random ready with occasional reloads (some of them zero seeds).
      for (int k = 0; k < 400; k++) begin
         num_ready = 1'($urandom % 2);
         seed_load = (($urandom % 40) == 0);
         seed_in   = (($urandom % 3) == 0) ? 16'h0000 : 16'($urandom);
         cycle();
      end
      seed_load = 1'b0;

      // Zero seed repairs to 1 and sets lockup.
      num_ready = 1'b1; seed_load = 1'b1; seed_in = 16'h0000;
      #1 chk("zero_load_valid", 2, 32'(o_val[2]), 32'd0);
      cycle();
      seed_load = 1'b0;
      chk("zero_load_num", 2, 32'(o_num[2]), 32'd1);
      chk("zero_load_lock", 2, 32'(o_lock[2]), 32'd1);

      // 0x5A load with a simultaneous ready; load wins, wrap after 255 fires.
      seed_load = 1'b1; seed_in = 16'h005A; num_ready = 1'b1;
      #1 chk("5a_load_valid", 2, 32'(o_val[2]), 32'd0);
      cycle();
      seed_load = 1'b0;
      chk("5a_load_num", 2, 32'(o_num[2]), 32'h5A);
      wrap_at = -1;
      for (int k = 0; k < 260; k++) begin
         if (o_wrap[2] === 1'b1 && wrap_at < 0) wrap_at = k;
         cycle();
      end
      chk("5a_wrap_after", 2, 32'(wrap_at), 32'd255);

      // Mid-sequence reset while seed_load is high clears lockup.
      for (int k = 0; k < 5; k++) cycle();
      rst = 1'b1; seed_load = 1'b1; seed_in = 16'h0000;
      cycle();
      cycle();
      rst = 1'b0; seed_load = 1'b0;
      #1;
      for (int i = 0; i < 6; i++) begin
         chk("post_rst_num", i, 32'(o_num[i]), 32'd1);
         chk("post_rst_lock", i, 32'(o_lock[i]), 32'd0);
         chk("post_rst_valid", i, 32'(o_val[i]), 32'd1);
      end

      // Full period of continuous fires from seed 1.
      for (int i = 0; i < 6; i++) wraps_seen[i] = 0;
      collect_en = 1'b1;
      for (int k = 0; k < 65537; k++) cycle();
      collect_en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk("distinct", i, distinct[i], period_of(i));
         chk("zero_state", i, zeros[i], 32'd0);
         chk("wrap_seen", i, 32'(wraps_seen[i] > 0), 32'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
